// File: rtl/ps2_host_cmd_tx.sv
// ps2_host_cmd_tx: sends one host-to-device PS/2 command byte (request, inhibit, 11-bit frame, ACK, timeout).
// Latency: INHIBIT_CYCLES of clock inhibit, then device-paced (11 device clocks); ACK/timeout ends the frame.
// Backpressure: cmd_ready only in IDLE; cmd_valid while busy is ignored; device clock paces every bit.
//
// Ports:
//   clk, reset               system clock, asynchronous active-high reset
//   cmd_data/valid/ready     command byte handshake (accepted when valid && ready)
//   busy                     high outside IDLE; tells the scan-code receiver to ignore line edges
//   tx_done / tx_error       1-cycle result pulses (ACK seen / timeout or missing ACK)
//   ps2_clk_in/ps2_data_in   raw (asynchronous) PS/2 line levels
//   ps2_clk_oe/ps2_data_oe   open-drain pull-down enables (1 = drive low, 0 = release)

module ps2_host_cmd_tx #(
  // Must be at least 2: the last inhibit cycle is spent presenting the start bit.
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  // The inhibit counter stops one short of INHIBIT_CYCLES because the START
  // cycle (clock still held low, data now low) completes the inhibit period.
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 2);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  // States are named after what the next falling device-clock edge does.
  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_INHIBIT   = 4'd1;
  localparam logic [3:0] S_START     = 4'd2;
  localparam logic [3:0] S_REQ       = 4'd3;  // fall #1 drives D0
  localparam logic [3:0] S_DATA      = 4'd4;  // falls #2..#8 drive D1..D7
  localparam logic [3:0] S_PARITY    = 4'd5;  // fall #9 drives parity
  localparam logic [3:0] S_STOP      = 4'd6;  // fall #10 releases data (stop)
  localparam logic [3:0] S_ACK       = 4'd7;  // fall #11 samples the device ACK
  localparam logic [3:0] S_WAIT_IDLE = 4'd8;

  logic [3:0]    state;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    shift;
  logic          parity;
  logic [2:0]    bit_cnt;

  // Two-flop synchronizers plus a history flop for falling-edge detection.
  // They reset to 1 so an idle (pulled-up) bus never looks like an edge.
  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_prev;
  logic       sclk;
  logic       sdata;
  logic       fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      clk_prev  <= clk_sync[1];
    end
  end

  assign sclk  = clk_sync[1];
  assign sdata = data_sync[1];
  assign fall  = clk_prev & ~sclk;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      inh_cnt     <= '0;
      tmo_cnt     <= '0;
      shift       <= 8'h00;
      parity      <= 1'b0;
      bit_cnt     <= 3'd0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;

      case (state)
        S_IDLE: begin
          // Line edges here belong to device-to-host traffic; only a command moves us.
          if (cmd_valid) begin
            shift       <= cmd_data;
            parity      <= ~^cmd_data;
            inh_cnt     <= '0;
            ps2_clk_oe  <= 1'b1;
            ps2_data_oe <= 1'b0;
            state       <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (inh_cnt == INH_LAST) begin
            ps2_data_oe <= 1'b1;  // start bit, presented while clock is still inhibited
            state       <= S_START;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end

        S_START: begin
          // Releasing the clock hands timing to the device; the timeout starts here.
          ps2_clk_oe <= 1'b0;
          tmo_cnt    <= '0;
          state      <= S_REQ;
        end

        default: begin
          if (tmo_cnt == TMO_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_error    <= 1'b1;
            state       <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            case (state)
              S_REQ: begin
                if (fall) begin
                  ps2_data_oe <= ~shift[0];
                  shift       <= {1'b0, shift[7:1]};
                  bit_cnt     <= 3'd0;
                  state       <= S_DATA;
                end
              end

              S_DATA: begin
                if (fall) begin
                  ps2_data_oe <= ~shift[0];
                  shift       <= {1'b0, shift[7:1]};
                  bit_cnt     <= bit_cnt + 3'd1;
                  // bit_cnt names the bit on the line; 6 -> 7 means D7 just went out.
                  if (bit_cnt == 3'd6) begin
                    state <= S_PARITY;
                  end
                end
              end

              S_PARITY: begin
                if (fall) begin
                  ps2_data_oe <= ~parity;
                  state       <= S_STOP;
                end
              end

              S_STOP: begin
                if (fall) begin
                  ps2_data_oe <= 1'b0;  // stop bit is the released (high) line
                  state       <= S_ACK;
                end
              end

              S_ACK: begin
                if (fall) begin
                  if (!sdata) begin
                    state <= S_WAIT_IDLE;
                  end else begin
                    tx_error <= 1'b1;
                    state    <= S_IDLE;
                  end
                end
              end

              S_WAIT_IDLE: begin
                // Done only once the device has let go of both lines.
                if (sclk && sdata) begin
                  tx_done <= 1'b1;
                  state   <= S_IDLE;
                end
              end

              default: begin
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                state       <= S_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_cmd_tx.sv
// tb_ps2_host_cmd_tx: drives ps2_host_cmd_tx against a simple PS/2 device model on open-drain lines.
// Latency: device clocks at 1/20 clk; each frame is checked bit by bit against a reference frame.
// Backpressure: commands issued only while cmd_ready; junk requests injected while busy.

module tb_ps2_host_cmd_tx;

  localparam int INH  = 20;
  localparam int TMO  = 2000;
  localparam int HALF = 10;

  localparam int M_ACK     = 0;
  localparam int M_NOACK   = 1;
  localparam int M_SILENT  = 2;
  localparam int M_ABORT   = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_error;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;

  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;

  // Open-drain wired-AND with pull-ups.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  ps2_host_cmd_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_error) err_cnt <= err_cnt + 1;
    if (tx_done && tx_error) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference frame as the device sees it on rising edges: D0..D7, odd parity, stop.
  function automatic logic [9:0] ref_frame(input logic [7:0] b);
    int ones;
    logic [9:0] f;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    f[7:0] = b;
    f[8]   = ((ones % 2) == 0) ? 1'b1 : 1'b0;
    f[9]   = 1'b1;
    return f;
  endfunction

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One command transaction. mode selects device behaviour; junk injects
  // cmd_valid/cmd_data noise while the block is busy.
  task automatic do_frame(input logic [7:0] b, input int mode, input bit junk);
    int lowc;
    int t;
    int rel;
    int d0;
    int e0;
    logic [9:0] got;
    logic [9:0] exp;

    exp = ref_frame(b);
    got = '0;
    @(negedge clk);
    chk("ready_before", cmd_ready, 1);
    cmd_data  = b;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    d0 = done_cnt;
    e0 = err_cnt;
    chk("busy_after_accept", busy, 1);
    chk("ready_while_busy", cmd_ready, 0);

    lowc = 0;
    t = 0;
    while (ps2_clk_oe && t < 1000) begin
      lowc++;
      if (junk) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_data  = 8'($urandom);
      end
      @(negedge clk);
      t++;
    end
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    chk("inhibit_len", lowc, INH);
    chk("start_bit", ps2_data_oe, 1);
    rel = cyc;

    if (mode == M_SILENT) begin
      t = 0;
      while (!tx_error && t < TMO + 1000) begin
        @(negedge clk);
        t++;
      end
      chk("timeout_cycles", cyc - rel, TMO);
      chk("timeout_clk_oe", ps2_clk_oe, 0);
      chk("timeout_data_oe", ps2_data_oe, 0);
      chk("timeout_busy", busy, 0);
      chk("timeout_no_done", tx_done, 0);
      wait_neg(5);
      chk("timeout_err_cnt", err_cnt - e0, 1);
      chk("timeout_done_cnt", done_cnt - d0, 0);
      return;
    end

    wait_neg($urandom_range(2, 8));
    for (int k = 1; k <= 11; k++) begin
      dev_clk_low = 1'b1;
      wait_neg(HALF);
      if (mode == M_ABORT && k == 5) return;
      dev_clk_low = 1'b0;
      if (k <= 10) got[k-1] = ps2_data_in;
      if (k == 10 && mode == M_ACK) dev_data_low = 1'b1;
      wait_neg(HALF);
      if (k == 11) dev_data_low = 1'b0;
    end
    for (int i = 0; i < 10; i++) chk($sformatf("frame_%02h_bit%0d", b, i), got[i], exp[i]);

    wait_neg(20);
    if (mode == M_ACK) begin
      chk("ack_done_cnt", done_cnt - d0, 1);
      chk("ack_err_cnt", err_cnt - e0, 0);
    end else begin
      chk("noack_done_cnt", done_cnt - d0, 0);
      chk("noack_err_cnt", err_cnt - e0, 1);
    end
    chk("end_ready", cmd_ready, 1);
    chk("end_busy", busy, 0);
    chk("end_clk_oe", ps2_clk_oe, 0);
    chk("end_data_oe", ps2_data_oe, 0);
  endtask

  initial begin
    int d0;
    int e0;

    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_error", tx_error, 0);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    wait_neg(3);
    reset = 1'b0;
    wait_neg(3);

    do_frame(8'hED, M_ACK, 1'b0);
    do_frame(8'hF4, M_ACK, 1'b0);
    do_frame(8'h00, M_ACK, 1'b0);
    do_frame(8'hFF, M_ACK, 1'b0);

    do_frame(8'($urandom), M_SILENT, 1'b0);

    do_frame(8'($urandom), M_NOACK, 1'b0);
    do_frame(8'hF4, M_ACK, 1'b0);

    // Reset in the middle of data bit 4: both lines must release immediately.
    d0 = done_cnt;
    e0 = err_cnt;
    do_frame(8'($urandom), M_ABORT, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_clk_oe", ps2_clk_oe, 0);
    chk("abort_data_oe", ps2_data_oe, 0);
    chk("abort_busy", busy, 0);
    dev_clk_low = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    wait_neg(5);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_no_err", err_cnt - e0, 0);
    do_frame(8'($urandom), M_ACK, 1'b0);

    do_frame(8'($urandom), M_ACK, 1'b1);

    for (int r = 0; r < 6; r++) begin
      wait_neg($urandom_range(0, 5));
      do_frame(8'($urandom), M_ACK, r[0]);
    end

    chk("done_err_exclusive", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
